// File: rtl/context_loader_if.sv
// Host-side and memory-side signal bundle for the context loader.
// CHKSUM_O exists only when CONTEXT_LOADER_CHECKSUM_EN is defined.
interface context_loader_if #(
  parameter int CTX_WIDTH  = 80,
  parameter int ADDR_WIDTH = 10,
  parameter int BUS_WIDTH  = 32
);
  logic                  START_I;
  logic [ADDR_WIDTH-1:0] BASE_I;
  logic [ADDR_WIDTH:0]   COUNT_I;
  logic [BUS_WIDTH-1:0]  DATA_I;
  logic                  VALID_I;
  logic                  READY_O;
  logic [ADDR_WIDTH-1:0] WR_ADDR_O;
  logic [CTX_WIDTH-1:0]  WR_DATA_O;
  logic                  WR_EN_O;
  logic                  BUSY_O;
  logic                  DONE_O;
  logic                  ERR_O;
`ifdef CONTEXT_LOADER_CHECKSUM_EN
  logic [BUS_WIDTH-1:0]  CHKSUM_O;

  modport slave (
    input  START_I, BASE_I, COUNT_I, DATA_I, VALID_I,
    output READY_O, WR_ADDR_O, WR_DATA_O, WR_EN_O, BUSY_O, DONE_O, ERR_O, CHKSUM_O
  );
  modport master (
    output START_I, BASE_I, COUNT_I, DATA_I, VALID_I,
    input  READY_O, WR_ADDR_O, WR_DATA_O, WR_EN_O, BUSY_O, DONE_O, ERR_O, CHKSUM_O
  );
`else
  modport slave (
    input  START_I, BASE_I, COUNT_I, DATA_I, VALID_I,
    output READY_O, WR_ADDR_O, WR_DATA_O, WR_EN_O, BUSY_O, DONE_O, ERR_O
  );
  modport master (
    output START_I, BASE_I, COUNT_I, DATA_I, VALID_I,
    input  READY_O, WR_ADDR_O, WR_DATA_O, WR_EN_O, BUSY_O, DONE_O, ERR_O
  );
`endif
endinterface

// File: rtl/context_loader.sv
// Packs a BUS_WIDTH beat stream into CTX_WIDTH entries written to consecutive context addresses.
// Optional feature macro: CONTEXT_LOADER_CHECKSUM_EN (XOR of all beats accepted in the job).
module context_loader #(
  parameter int CTX_WIDTH  = 80,
  parameter int ADDR_WIDTH = 10,
  parameter int MEM_LENGTH = 1024,
  parameter int BUS_WIDTH  = 32
) (
  input logic             CLK_I,
  input logic             RST_I,
  context_loader_if.slave bus
);
  localparam int BEATS  = (CTX_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PACK_W = BEATS * BUS_WIDTH;
  localparam logic [BEAT_W-1:0]   LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH:0] MEM_LEN   = (ADDR_WIDTH + 1)'(MEM_LENGTH);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_LOAD, S_FINISH} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [PACK_W-1:0]     pack_q, pack_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [CTX_WIDTH-1:0]  wr_data_q, wr_data_d;

  logic [ADDR_WIDTH:0]   end_addr;
  logic                  range_err;
  logic                  ready;
  logic                  accept;
  logic [BEATS-1:0]      lane_we;

  // addr_q still holds BASE while in CHECK, so the sum is the job's end address.
  assign end_addr  = {1'b0, addr_q} + rem_q;
  assign range_err = end_addr > MEM_LEN;
  assign ready     = (state_q == S_LOAD) && (rem_q != '0);
  assign accept    = ready && bus.VALID_I;

  for (genvar gi = 0; gi < BEATS; gi++) begin : g_lane
    assign lane_we[gi] = accept && (beat_q == BEAT_W'(gi));
    assign pack_d[gi*BUS_WIDTH +: BUS_WIDTH] =
      lane_we[gi] ? bus.DATA_I : pack_q[gi*BUS_WIDTH +: BUS_WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    beat_d    = beat_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      S_IDLE: begin
        if (bus.START_I) begin
          addr_d  = bus.BASE_I;
          rem_d   = bus.COUNT_I;
          beat_d  = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (range_err)            state_d = S_IDLE;
        else if (rem_q == '0)     state_d = S_FINISH;
        else                      state_d = S_LOAD;
      end
      S_LOAD: begin
        // rem_q reaching zero means the final write is on the bus this cycle.
        if (rem_q == '0) begin
          state_d = S_FINISH;
        end else if (accept) begin
          if (beat_q == LAST_BEAT) begin
            beat_d    = '0;
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = pack_d[CTX_WIDTH-1:0];
            addr_d    = addr_q + 1'b1;
            rem_d     = rem_q - 1'b1;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      beat_q    <= '0;
      pack_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      beat_q    <= beat_d;
      pack_q    <= pack_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.READY_O   = ready;
  assign bus.WR_EN_O   = wr_en_q;
  assign bus.WR_ADDR_O = wr_addr_q;
  assign bus.WR_DATA_O = wr_data_q;
  assign bus.BUSY_O    = (state_q != S_IDLE);
  assign bus.DONE_O    = (state_q == S_FINISH);
  assign bus.ERR_O     = (state_q == S_CHECK) && range_err;

`ifdef CONTEXT_LOADER_CHECKSUM_EN
  logic [BUS_WIDTH-1:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (state_q == S_IDLE && bus.START_I) chk_d = '0;
    else if (accept)                      chk_d = chk_q ^ bus.DATA_I;
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) chk_q <= '0;
    else       chk_q <= chk_d;
  end

  assign bus.CHKSUM_O = chk_q;
`endif
endmodule

// File: tb/tb_context_loader.sv
// Randomized scoreboard bench for context_loader; expected writes/events are queued by the driver
// and checked by an independent monitor. Checksum checks follow CONTEXT_LOADER_CHECKSUM_EN.
module tb_context_loader;
  localparam int CTX_WIDTH  = 80;
  localparam int ADDR_WIDTH = 10;
  localparam int MEM_LENGTH = 1024;
  localparam int BUS_WIDTH  = 32;
  localparam int BEATS      = (CTX_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int PACK_W     = BEATS * BUS_WIDTH;

  typedef struct {
    logic [ADDR_WIDTH-1:0] addr;
    logic [CTX_WIDTH-1:0]  data;
  } wr_t;
  typedef struct {
    int                   kind;  // 1 = done, 2 = range error
    logic [BUS_WIDTH-1:0] chk;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  context_loader_if #(.CTX_WIDTH(CTX_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .BUS_WIDTH(BUS_WIDTH)) bus ();

  context_loader #(
    .CTX_WIDTH(CTX_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .MEM_LENGTH(MEM_LENGTH), .BUS_WIDTH(BUS_WIDTH)
  ) dut (
    .CLK_I(clk),
    .RST_I(rst),
    .bus  (bus.slave)
  );

  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  wr_t exp_wr[$];
  ev_t exp_ev[$];
  int  wr_cycles[$];
  int  done_cyc;
  int  err_cyc;
  int  busy_low_cyc;
  int  ready_drop;
  bit  seen_ready;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or a status pulse.
  always @(negedge clk) begin
    if (bus.READY_O) seen_ready = 1'b1;
    if (bus.WR_EN_O) begin
      wr_cycles.push_back(cyc);
      $display("write addr=%0d data=%h", bus.WR_ADDR_O, bus.WR_DATA_O);
      if (exp_wr.size() == 0) begin
        total++; bad++;
        $display("FAIL wr_unexpected: got addr %0d data %h expected no write", bus.WR_ADDR_O, bus.WR_DATA_O);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        check("wr_addr", 128'(bus.WR_ADDR_O), 128'(e.addr));
        check("wr_data", 128'(bus.WR_DATA_O), 128'(e.data));
      end
    end
    if (bus.DONE_O || bus.ERR_O) begin
      int kind;
      kind = bus.ERR_O ? 2 : 1;
      if (bus.DONE_O) done_cyc = cyc;
      if (bus.ERR_O)  err_cyc  = cyc;
      $display("event %s at cycle %0d", (kind == 1) ? "done" : "err", cyc);
      if (exp_ev.size() == 0) begin
        total++; bad++;
        $display("FAIL ev_unexpected: got event kind %0d expected none", kind);
      end else begin
        ev_t e;
        e = exp_ev.pop_front();
        check("ev_kind", 128'(kind), 128'(e.kind));
        check("done_err_both", 128'(bus.DONE_O & bus.ERR_O), 128'(0));
`ifdef CONTEXT_LOADER_CHECKSUM_EN
        if (e.kind == 1) check("chksum", 128'(bus.CHKSUM_O), 128'(e.chk));
`endif
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},   128'(bus.READY_O),   128'(0));
    check({tag, "_wr_en"},   128'(bus.WR_EN_O),   128'(0));
    check({tag, "_wr_addr"}, 128'(bus.WR_ADDR_O), 128'(0));
    check({tag, "_wr_data"}, 128'(bus.WR_DATA_O), 128'(0));
    check({tag, "_busy"},    128'(bus.BUSY_O),    128'(0));
    check({tag, "_done"},    128'(bus.DONE_O),    128'(0));
    check({tag, "_err"},     128'(bus.ERR_O),     128'(0));
  endtask

  // Issues one job; abort_after>0 resets the DUT once that many beats were accepted.
  task automatic run_job(input int base, input int count, input int mode,
                         input int abort_after, input bit fixed_data, output int start_cyc);
    logic [BUS_WIDTH-1:0] beats[$];
    logic [PACK_W-1:0]    w;
    logic [BUS_WIDTH-1:0] xsum;
    int  n_beats, limit, n_entries, idx, k, guard;
    bit  out_of_range, acc, valid;

    n_beats = count * BEATS;
    for (int i = 0; i < n_beats; i++)
      beats.push_back(fixed_data ? BUS_WIDTH'(32'h11111111 * (i + 1)) : BUS_WIDTH'($urandom));
    out_of_range = (base + count) > MEM_LENGTH;
    limit        = out_of_range ? 0 : ((abort_after > 0) ? abort_after : n_beats);
    n_entries    = limit / BEATS;

    // Reference model: each entry is its beats concatenated LSB-first, truncated to CTX_WIDTH.
    xsum = '0;
    for (int e = 0; e < n_entries; e++) begin
      w = '0;
      for (int b = 0; b < BEATS; b++)
        w = w | (PACK_W'(beats[e*BEATS + b]) << (b * BUS_WIDTH));
      exp_wr.push_back('{addr: ADDR_WIDTH'(base + e), data: w[CTX_WIDTH-1:0]});
    end
    for (int i = 0; i < limit; i++) xsum = xsum ^ beats[i];
    if (out_of_range)          exp_ev.push_back('{kind: 2, chk: '0});
    else if (abort_after == 0) exp_ev.push_back('{kind: 1, chk: xsum});

    $display("job base=%0d count=%0d mode=%0d abort=%0d", base, count, mode, abort_after);
    wr_cycles.delete();
    done_cyc = -1; err_cyc = -1; ready_drop = 0; seen_ready = 1'b0;

    @(posedge clk); #1;
    start_cyc   = cyc;
    bus.START_I = 1'b1;
    bus.BASE_I  = ADDR_WIDTH'(base);
    bus.COUNT_I = (ADDR_WIDTH + 1)'(count);
    bus.VALID_I = 1'b0;
    @(posedge clk); #1;
    bus.START_I = 1'b0;

    idx = 0; k = 0; guard = 0;
    while (idx < limit && guard < 2000) begin
      case (mode)
        0:       valid = 1'b1;
        1:       valid = (k % 2) == 0;
        default: valid = $urandom_range(0, 2) != 0;
      endcase
      bus.VALID_I = valid;
      bus.DATA_I  = beats[idx];
      @(negedge clk);
      acc = bus.VALID_I && bus.READY_O;
      if (idx > 0 && !bus.READY_O) ready_drop++;
      @(posedge clk); #1;
      if (acc) idx++;
      k++; guard++;
    end
    bus.VALID_I = 1'b0;
    if (guard >= 2000) begin
      total++; bad++;
      $display("FAIL beat_timeout: got %0d beats accepted expected %0d", idx, limit);
    end

    if (abort_after > 0) begin
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_outputs("abort");
      rst = 1'b0;
      @(posedge clk); #1;
    end else begin
      guard = 0;
      while (guard < 50) begin
        @(negedge clk);
        if (!bus.BUSY_O) break;
        guard++;
      end
      busy_low_cyc = cyc;
      if (guard >= 50) begin
        total++; bad++;
        $display("FAIL busy_timeout: got BUSY_O still high expected low within 50 cycles");
      end
    end
    check("wr_queue_empty", 128'(exp_wr.size()), 128'(0));
    check("ev_queue_empty", 128'(exp_ev.size()), 128'(0));
    exp_wr.delete();
    exp_ev.delete();
  endtask

  initial begin
    int st;
    rst         = 1'b1;
    bus.START_I = 1'b0;
    bus.BASE_I  = '0;
    bus.COUNT_I = '0;
    bus.DATA_I  = '0;
    bus.VALID_I = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Back-to-back beats: latency and write/done spacing.
    run_job(5, 2, 0, 0, 1'b1, st);
    check("t1_nwrites", 128'(wr_cycles.size()), 128'(2));
    if (wr_cycles.size() == 2) begin
      check("t1_first_wr_latency", 128'(wr_cycles[0] - st), 128'(BEATS + 2));
      check("t1_done_after_wr", 128'(done_cyc - wr_cycles[1]), 128'(1));
    end

    // VALID_I low every other cycle.
    run_job(5, 2, 1, 0, 1'b1, st);
    check("t2_nwrites", 128'(wr_cycles.size()), 128'(2));
    check("t2_ready_drop", 128'(ready_drop), 128'(0));

    // Range boundary.
    run_job(1020, 5, 0, 0, 1'b0, st);
    check("t3_nwrites", 128'(wr_cycles.size()), 128'(0));
    check("t3_err_seen", 128'(err_cyc - st), 128'(1));
    check("t3_busy_low", 128'((busy_low_cyc - st) <= 3), 128'(1));
    run_job(1020, 4, 2, 0, 1'b0, st);
    check("t3b_nwrites", 128'(wr_cycles.size()), 128'(4));

    // Empty job; also re-clears the checksum after the previous job.
    run_job(7, 0, 0, 0, 1'b0, st);
    check("t4_nwrites", 128'(wr_cycles.size()), 128'(0));
    check("t4_done_latency", 128'(done_cyc - st), 128'(2));
    check("t4_ready_never", 128'(seen_ready), 128'(0));

    // Reset after four beats, then a clean job.
    run_job(40, 2, 0, 4, 1'b1, st);
    check("t5_nwrites", 128'(wr_cycles.size()), 128'(1));
    check("t5_no_done", 128'(done_cyc), 128'(-1));
    run_job(5, 2, 0, 0, 1'b1, st);
    check("t5b_nwrites", 128'(wr_cycles.size()), 128'(2));

    // Randomized jobs.
    for (int j = 0; j < 30; j++) begin
      int b, c, m;
      c = $urandom_range(0, 5);
      b = ($urandom_range(0, 3) == 0) ? (1018 + $urandom_range(0, 5)) : $urandom_range(0, 1000);
      m = $urandom_range(0, 2);
      run_job(b, c, m, 0, 1'b0, st);
      if (b + c <= MEM_LENGTH)
        check("rnd_nwrites", 128'(wr_cycles.size()), 128'(c));
      else
        check("rnd_nwrites_err", 128'(wr_cycles.size()), 128'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
